writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_pkg.sv | 11 +
 rtl/writeback_match.sv | 37 +++
 rtl/writeback_queue.sv | 115 +++++++++++
 tb/tb_writeback_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared widths and the queued-write entry type for the register writeback queue.
package writeback_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] value;
    } wb_entry_t;
endpackage

// File: rtl/writeback_match.sv
// Youngest-match forwarding lookup over the pending queue, falling back to the
// register-file output register when no queued entry matches.
module writeback_match
    import writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]      entries,
    input  logic [DEPTH-1:0]           entry_valid,
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [ADDR_W-1:0]          query,
    input  logic                       rf_mode,
    input  wb_entry_t                  rf_entry,
    output logic                       hit,
    output logic [DATA_W-1:0]          hit_value
);
    localparam int PTR_W = $clog2(DEPTH);

    always_comb begin
        logic [PTR_W-1:0] idx;
        hit       = 1'b0;
        hit_value = '0;
        idx       = '0;
        if (rf_mode && rf_entry.address == query) begin
            hit       = 1'b1;
            hit_value = rf_entry.value;
        end
        // Walk oldest to youngest so the last match (youngest) wins.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (entry_valid[idx] && entries[idx].address == query) begin
                hit       = 1'b1;
                hit_value = entries[idx].value;
            end
        end
    end
endmodule

// File: rtl/writeback_queue.sv
// FIFO of pending register writes draining one per cycle into the register file,
// with two independent combinational forwarding ports.
module writeback_queue
    import writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [ADDR_W-1:0]          InAddress,
    input  logic [DATA_W-1:0]          InValue,
    input  logic                       DrainEnable,
    output logic                       RfMode,
    output logic [ADDR_W-1:0]          RfWriteAddress,
    output logic [DATA_W-1:0]          RfWriteValue,
    input  logic [ADDR_W-1:0]          QueryAddress1,
    input  logic [ADDR_W-1:0]          QueryAddress2,
    output logic                       Hit1,
    output logic                       Hit2,
    output logic [DATA_W-1:0]          HitValue1,
    output logic [DATA_W-1:0]          HitValue2,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Empty,
    output logic                       Full
);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int NUM_PORTS = 2;

    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_valid;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  push;
    logic                  pop;
    wb_entry_t             rf_entry;

    // Ready depends on occupancy only: a same-cycle pop never frees a full queue.
    assign Full    = (Count == CNT_W'(DEPTH));
    assign Empty   = (Count == '0);
    assign InReady = !Full;
    assign push    = InValid && InReady;
    assign pop     = DrainEnable && !Empty;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            head        <= '0;
            tail        <= '0;
            Count       <= '0;
            entry_valid <= '0;
        end else begin
            if (push) begin
                tail              <= tail + PTR_W'(1);
                entry_valid[tail] <= 1'b1;
            end
            if (pop) begin
                head              <= head + PTR_W'(1);
                entry_valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   Count <= Count + CNT_W'(1);
                2'b01:   Count <= Count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            entries[tail] <= '{address: InAddress, value: InValue};
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RfMode         <= 1'b0;
            RfWriteAddress <= '0;
            RfWriteValue   <= '0;
        end else begin
            RfMode <= pop;
            if (pop) begin
                RfWriteAddress <= entries[head].address;
                RfWriteValue   <= entries[head].value;
            end
        end
    end

    assign rf_entry = '{address: RfWriteAddress, value: RfWriteValue};

    logic [NUM_PORTS-1:0][ADDR_W-1:0] query;
    logic [NUM_PORTS-1:0]             hit;
    logic [NUM_PORTS-1:0][DATA_W-1:0] hit_value;

    assign query = {QueryAddress2, QueryAddress1};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_match
        writeback_match #(.DEPTH(DEPTH)) u_match (
            .entries     (entries),
            .entry_valid (entry_valid),
            .head        (head),
            .query       (query[p]),
            .rf_mode     (RfMode),
            .rf_entry    (rf_entry),
            .hit         (hit[p]),
            .hit_value   (hit_value[p])
        );
    end

    assign Hit1      = hit[0];
    assign Hit2      = hit[1];
    assign HitValue1 = hit_value[0];
    assign HitValue2 = hit_value[1];
endmodule

// File: tb/tb_writeback_queue.sv
// Randomized plus directed bench for writeback_queue: a queue-based reference model
// predicts drains into a scoreboard that a separate monitor checks against the Rf outputs.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] v;
    } ent_t;

    logic        Clock, Reset_n;
    logic        InValid, InReady, DrainEnable;
    logic [4:0]  InAddress, QueryAddress1, QueryAddress2, RfWriteAddress;
    logic [15:0] InValue, RfWriteValue, HitValue1, HitValue2;
    logic        RfMode, Hit1, Hit2, Empty, Full;
    logic [2:0]  Count;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .InValid(InValid), .InReady(InReady), .InAddress(InAddress), .InValue(InValue),
        .DrainEnable(DrainEnable), .RfMode(RfMode),
        .RfWriteAddress(RfWriteAddress), .RfWriteValue(RfWriteValue),
        .QueryAddress1(QueryAddress1), .QueryAddress2(QueryAddress2),
        .Hit1(Hit1), .Hit2(Hit2), .HitValue1(HitValue1), .HitValue2(HitValue2),
        .Count(Count), .Empty(Empty), .Full(Full)
    );

    always #5 Clock = ~Clock;

    ent_t        model[$];
    ent_t        exp_q[$];
    logic        mrf_mode;
    logic [4:0]  mrf_addr;
    logic [15:0] mrf_val;
    int          checks, errors;
    logic        done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest pending write to q wins; else the last drained write if still presented.
    task automatic ref_hit(input logic [4:0] q, output logic h, output logic [15:0] hv);
        h  = 1'b0;
        hv = '0;
        for (int i = model.size() - 1; i >= 0; i--) begin
            if (model[i].a == q) begin
                h  = 1'b1;
                hv = model[i].v;
                break;
            end
        end
        if (!h && mrf_mode && mrf_addr == q) begin
            h  = 1'b1;
            hv = mrf_val;
        end
    endtask

    task automatic step(input logic v, input logic [4:0] a, input logic [15:0] d,
                        input logic de, input logic [4:0] q1, input logic [4:0] q2);
        logic        h;
        logic [15:0] hv;
        logic        do_push, do_pop;
        ent_t        e;
        @(negedge Clock);
        InValid = v; InAddress = a; InValue = d; DrainEnable = de;
        QueryAddress1 = q1; QueryAddress2 = q2;
        #1;
        chk("count", 32'(Count), 32'(model.size()));
        chk("empty", 32'(Empty), 32'(model.size() == 0));
        chk("full", 32'(Full), 32'(model.size() == DEPTH));
        chk("in_ready", 32'(InReady), 32'(model.size() < DEPTH));
        ref_hit(q1, h, hv);
        chk("hit1", 32'(Hit1), 32'(h));
        chk("hit_value1", 32'(HitValue1), 32'(hv));
        ref_hit(q2, h, hv);
        chk("hit2", 32'(Hit2), 32'(h));
        chk("hit_value2", 32'(HitValue2), 32'(hv));
        @(posedge Clock);
        do_push = v && (model.size() < DEPTH);
        do_pop  = de && (model.size() > 0);
        if (do_pop) begin
            e = model.pop_front();
            exp_q.push_back(e);
            mrf_mode = 1'b1;
            mrf_addr = e.a;
            mrf_val  = e.v;
        end else begin
            mrf_mode = 1'b0;
        end
        if (do_push) model.push_back('{a, d});
    endtask

    task automatic drain();
        repeat (DEPTH + 2) step(1'b0, 5'd0, 16'h0, 1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rf_mode"}, 32'(RfMode), 32'd0);
        chk({tag, "_rf_addr"}, 32'(RfWriteAddress), 32'd0);
        chk({tag, "_rf_value"}, 32'(RfWriteValue), 32'd0);
        chk({tag, "_count"}, 32'(Count), 32'd0);
        chk({tag, "_empty"}, 32'(Empty), 32'd1);
        chk({tag, "_full"}, 32'(Full), 32'd0);
        chk({tag, "_in_ready"}, 32'(InReady), 32'd1);
        chk({tag, "_hit1"}, 32'(Hit1), 32'd0);
        chk({tag, "_hit2"}, 32'(Hit2), 32'd0);
    endtask

    task automatic mid_reset();
        @(negedge Clock);
        #2;
        Reset_n = 1'b0; InValid = 1'b0; DrainEnable = 1'b0;
        #1;
        reset_checks("mid_reset");
        model.delete();
        exp_q.delete();
        mrf_mode = 1'b0; mrf_addr = '0; mrf_val = '0;
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic monitor();
        ent_t e;
        while (!done) begin
            @(posedge Clock);
            #1;
            if (Reset_n && RfMode) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rf_unexpected: got write addr %0d value 0x%0h, expected no write at %0t",
                             RfWriteAddress, RfWriteValue, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_write", 32'({RfWriteAddress, RfWriteValue}), 32'({e.a, e.v}));
                end
            end
        end
    endtask

    task automatic stimulus();
        // Single write drains through the Rf register exactly once.
        step(1'b1, 5'd3, 16'h1111, 1'b1, 5'd3, 5'd0);
        step(1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 5'd0);
        #2;
        chk("single_rf_mode", 32'(RfMode), 32'd1);
        chk("single_rf_addr", 32'(RfWriteAddress), 32'd3);
        chk("single_rf_value", 32'(RfWriteValue), 32'h1111);
        step(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0);
        #2;
        chk("single_rf_mode_drop", 32'(RfMode), 32'd0);
        chk("single_empty", 32'(Empty), 32'd1);

        // Fill to full; the fifth request is refused and never drains.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 5'(i), 16'h5000 + 16'(i), 1'b0, 5'(i), 5'd0);
        #2;
        chk("fill_full", 32'(Full), 32'd1);
        chk("fill_in_ready", 32'(InReady), 32'd0);
        chk("fill_count", 32'(Count), 32'd4);
        step(1'b1, 5'd20, 16'hDEAD, 1'b0, 5'd20, 5'd20);
        drain();

        // Same-address writes: youngest forwards, both drain in order.
        step(1'b1, 5'd7, 16'hAAAA, 1'b0, 5'd7, 5'd7);
        step(1'b1, 5'd7, 16'hBBBB, 1'b0, 5'd7, 5'd7);
        #2;
        chk("same_addr_hit1", 32'(Hit1), 32'd1);
        chk("same_addr_value1", 32'(HitValue1), 32'hBBBB);
        drain();

        // Full queue with continuous push+pop exercises pointer wrap.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 5'(i + 10), 16'($urandom), 1'b0, 5'(i + 10), 5'd0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'($urandom_range(0, 15)), 16'($urandom), 1'b1,
                 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        drain();

        // Forwarding from queue before the pop edge, from Rf register after it.
        step(1'b1, 5'd9, 16'h1234, 1'b0, 5'd0, 5'd9);
        #2;
        chk("pop_fwd_queue_hit2", 32'(Hit2), 32'd1);
        chk("pop_fwd_queue_value2", 32'(HitValue2), 32'h1234);
        step(1'b0, 5'd0, 16'h0, 1'b1, 5'd0, 5'd9);
        #2;
        chk("pop_fwd_rf_mode", 32'(RfMode), 32'd1);
        chk("pop_fwd_rf_hit2", 32'(Hit2), 32'd1);
        chk("pop_fwd_rf_value2", 32'(HitValue2), 32'h1234);

        // Pending writes are discarded by a mid-operation reset.
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd12, 16'h7700 + 16'(i), 1'b0, 5'd12, 5'd12);
        mid_reset();
        for (int i = 0; i < 4; i++)
            step(1'b0, 5'd0, 16'h0, 1'b1, 5'd12, 5'd12);

        // Random traffic in three load phases.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 120; i++) begin
                logic       v, de;
                logic [4:0] a;
                v  = $urandom_range(0, 99) < (ph == 0 ? 80 : 50);
                de = $urandom_range(0, 99) < (ph == 0 ? 30 : (ph == 1 ? 90 : 55));
                a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                step(v, a, 16'($urandom), de, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        drain();
        step(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0);
        #2;
        chk("all_drained", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
    endtask

    initial begin
        Clock = 1'b0; Reset_n = 1'b1; done = 1'b0;
        InValid = 1'b0; InAddress = '0; InValue = '0; DrainEnable = 1'b0;
        QueryAddress1 = '0; QueryAddress2 = '0;
        mrf_mode = 1'b0; mrf_addr = '0; mrf_val = '0;
        checks = 0; errors = 0;
        #1 Reset_n = 1'b0;
        #2 reset_checks("reset");
        @(negedge Clock);
        Reset_n = 1'b1;
        fork
            stimulus();
            monitor();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
